io_stim_monitor: RTL and testbench
==================================

// Module: io_stim_monitor
// PURPOSE
//  Synthesisable run-control and I/O harness for the miniSRC CPU, one generation up from a fixed-value in-port bench.
//  Feeds the CPU in-port from a loadable STIM_DEPTH-entry table and asserts stop when run falls or a cycle timeout expires.
//  Logs every out-port value change into a LOG_DEPTH FIFO for readback.
//  Sits between the CPU top level and the board/bench I/O.
// PARAMETERS
//  DATA_W     32    in/out port data width
//  STIM_DEPTH 8     stimulus table entries (power of 2)
//  LOG_DEPTH  16    out-port log FIFO entries (power of 2)
//  TIMEOUT    4096  max RUN cycles before forced stop (>=1)
// PORTS
//  clock         in   1                      system clock, rising edge
//  reset         in   1                      asynchronous, active-high; clears all state
//  start         in   1                      pulse: begin a run
//  stim_wr_en    in   1                      write stimulus table entry
//  stim_wr_addr  in   clog2(STIM_DEPTH)      table address
//  stim_wr_data  in   DATA_W                 table data
//  stim_len      in   clog2(STIM_DEPTH)+1    valid entries, 1..STIM_DEPTH (0 treated as 1)
//  run           in   1                      CPU running flag
//  in_ack        in   1                      CPU consumed current in-port value (1-cycle pulse)
//  outPortData   in   DATA_W                 CPU out-port register
//  stop          out  1                      halt request to CPU
//  inPort_en     out  1                      in-port data valid
//  inPortDataIn  out  DATA_W                 data presented to CPU in-port
//  log_rd_en     in   1                      pop log FIFO
//  log_rd_data   out  DATA_W                 log head (valid when !log_empty)
//  log_empty     out  1                      FIFO empty
//  log_count     out  clog2(LOG_DEPTH)+1     FIFO occupancy
//  log_overflow  out  1                      sticky: push dropped while full
//  done          out  1                      run ended by CPU (run fell)
//  timed_out     out  1                      run ended by timeout
//  cycle_count   out  32                     cycles spent in RUN, saturating
// BEHAVIOUR
//  Reset values: stop=1, inPort_en=0, inPortDataIn=0, log_empty=1, log_count=0, log_overflow=0, done=0, timed_out=0,
//  cycle_count=0, ptr=0, out-port shadow=0, state=IDLE. Stim table is not reset.
//  FSM: IDLE -start-> RUN; RUN -run==0-> HALTED; RUN -cycle_count==TIMEOUT-1 & run-> TIMEOUT.
//  HALTED and TIMEOUT -start-> RUN.
//  Entering RUN: ptr=0, cycle_count=0, done=0, timed_out=0; log and overflow are kept.
//  Outputs: stop=0 only in RUN (registered, takes effect the cycle after entry). inPort_en=1 only in RUN.
//  inPortDataIn=stim[ptr], combinational from the table. Table writes take effect the next cycle, including during RUN.
//  Run-fall and timeout in the same cycle: HALTED wins (done=1, timed_out=0).
//  start while in RUN: ignored.
//  in_ack in RUN: ptr advances; see CONFIGURATION for the action at ptr==stim_len-1. in_ack outside RUN: ignored.
//  Log: every cycle, if outPortData != shadow, push outPortData and update shadow. Active in all states.
//  A first write of 0 after reset is not logged.
//  Push while full: data dropped, log_overflow=1, shadow still updated.
//  Push and pop in the same cycle: both occur, count unchanged.
//  Pop while empty: ignored.
//  log_rd_data is first-word-fall-through.
//  cycle_count increments each RUN cycle, saturates at 2^32-1, and holds after exit.
//  Reset mid-run: immediate return to reset values; stop=1 asynchronously.
// CONFIGURATION
//  STIM_LOOP_EN defined: ptr wraps to 0 after stim_len-1; inPort_en stays 1 for the whole RUN.
//  STIM_LOOP_EN undefined: after in_ack at the last entry, ptr holds and inPort_en drops to 0 for the rest of the run.
//  A further in_ack is then ignored.
// TESTING
//  T1 reset: assert reset mid-RUN -> stop=1 immediately, all flags/counts 0, state IDLE.
//  T2 stimulus: table {0x80,0x11,0x22}, stim_len=3, start, 3 in_ack pulses -> inPortDataIn 0x80,0x11,0x22.
//     Then 0x80 with inPort_en=1 (loop) or 0x22 with inPort_en=0 (no loop).
//  T3 halt: start, run=1 for 50 cycles then 0 -> next cycle stop=1, done=1, timed_out=0, cycle_count=50.
//  T4 timeout: TIMEOUT=16, run held 1 -> after 16 RUN cycles stop=1, timed_out=1. Run-fall in the timeout cycle -> done=1 only.
//  T5 log: outPortData 0->5->5->9 -> log holds 5,9, count=2. LOG_DEPTH+1 distinct values, no pops -> count=LOG_DEPTH, overflow=1.
//  T6 log push and pop in the same cycle at full -> count stays LOG_DEPTH, order preserved, overflow unchanged.

Source files
------------

// File: rtl/io_stim_monitor.sv
// io_stim_monitor: run-control and I/O harness for the miniSRC CPU (stimulus table, stop control, out-port log FIFO).
// Optional feature macro: STIM_LOOP_EN (stimulus table replays cyclically for the whole run).
module io_stim_monitor #(
  parameter int DATA_W     = 32,
  parameter int STIM_DEPTH = 8,
  parameter int LOG_DEPTH  = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stim_wr_en,
  input  logic [$clog2(STIM_DEPTH)-1:0] stim_wr_addr,
  input  logic [DATA_W-1:0]             stim_wr_data,
  input  logic [$clog2(STIM_DEPTH):0]   stim_len,
  input  logic                          run,
  input  logic                          in_ack,
  input  logic [DATA_W-1:0]             outPortData,
  output logic                          stop,
  output logic                          inPort_en,
  output logic [DATA_W-1:0]             inPortDataIn,
  input  logic                          log_rd_en,
  output logic [DATA_W-1:0]             log_rd_data,
  output logic                          log_empty,
  output logic [$clog2(LOG_DEPTH):0]    log_count,
  output logic                          log_overflow,
  output logic                          done,
  output logic                          timed_out,
  output logic [31:0]                   cycle_count
);
  localparam int          SA       = $clog2(STIM_DEPTH);
  localparam int          LA       = $clog2(LOG_DEPTH);
  localparam logic [31:0] CYC_LAST = 32'(TIMEOUT - 1);
  localparam logic [SA:0] LEN_ONE  = (SA+1)'(1);
  localparam logic [SA:0] LEN_MAX  = (SA+1)'(STIM_DEPTH);
  localparam logic [LA:0] LOG_FULL = (LA+1)'(LOG_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALTED, ST_TIMEOUT} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_stim [STIM_DEPTH];
  logic [SA-1:0]       r_ptr;
  logic                r_stop;
  logic                r_in_en;
  logic                r_done;
  logic                r_timed_out;
  logic [31:0]         r_cycles;

  logic [DATA_W-1:0]   r_log [LOG_DEPTH];
  logic [DATA_W-1:0]   r_shadow;
  logic [LA-1:0]       r_wr_ptr;
  logic [LA-1:0]       r_rd_ptr;
  logic [LA:0]         r_count;
  logic                r_overflow;

  logic [SA:0]         w_len;
  logic [SA-1:0]       w_last;
  logic                w_change;
  logic                w_full;
  logic                w_pop;
  logic                w_push;

  // NOTE: every branch assigns w_len, so no latch can be inferred here.
  always_comb begin
    if (stim_len == '0)          w_len = LEN_ONE;
    else if (stim_len > LEN_MAX) w_len = LEN_MAX;
    else                         w_len = stim_len;
  end
  assign w_last = SA'(w_len - LEN_ONE);

  // NOTE: storage arrays carry no reset; pointers and counts alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (stim_wr_en) r_stim[stim_wr_addr] <= stim_wr_data;
  end

  // NOTE: all state here uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_stop      <= 1'b1;
      r_in_en     <= 1'b0;
      r_ptr       <= '0;
      r_done      <= 1'b0;
      r_timed_out <= 1'b0;
      r_cycles    <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!run) begin
            r_state <= ST_HALTED;
            r_done  <= 1'b1;
            r_stop  <= 1'b1;
            r_in_en <= 1'b0;
          end else begin
            if (r_cycles != '1) r_cycles <= r_cycles + 32'd1;
            if (r_cycles == CYC_LAST) begin
              r_state     <= ST_TIMEOUT;
              r_timed_out <= 1'b1;
              r_stop      <= 1'b1;
              r_in_en     <= 1'b0;
            end
          end
          if (in_ack && r_in_en) begin
            if (r_ptr != w_last) r_ptr <= r_ptr + SA'(1);
`ifdef STIM_LOOP_EN
            else                 r_ptr <= '0;
`else
            else                 r_in_en <= 1'b0;
`endif
          end
        end
        default: begin
          if (start) begin
            r_state     <= ST_RUN;
            r_stop      <= 1'b0;
            r_in_en     <= 1'b1;
            r_ptr       <= '0;
            r_cycles    <= '0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
          end
        end
      endcase
    end
  end

  // A change is pushed unless full without a simultaneous pop; the shadow tracks every value regardless.
  assign w_change = (outPortData != r_shadow);
  assign w_full   = (r_count == LOG_FULL);
  assign w_pop    = log_rd_en && (r_count != '0);
  assign w_push   = w_change && (!w_full || w_pop);

  always_ff @(posedge clock) begin
    if (w_push) r_log[r_wr_ptr] <= outPortData;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shadow   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_shadow <= outPortData;
      if (w_push) r_wr_ptr <= r_wr_ptr + LA'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LA'(1);
      if (w_push && !w_pop)      r_count <= r_count + (LA+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (LA+1)'(1);
      if (w_change && !w_push) r_overflow <= 1'b1;
    end
  end

  assign stop         = r_stop;
  assign inPort_en    = r_in_en;
  assign inPortDataIn = (r_state == ST_RUN) ? r_stim[r_ptr] : '0;
  assign log_rd_data  = r_log[r_rd_ptr];
  assign log_empty    = (r_count == '0);
  assign log_count    = r_count;
  assign log_overflow = r_overflow;
  assign done         = r_done;
  assign timed_out    = r_timed_out;
  assign cycle_count  = r_cycles;

endmodule

// File: tb/tb_io_stim_monitor.sv
// Directed bench for io_stim_monitor: reset, stimulus table, halt, timeout, out-port log FIFO.
module tb_io_stim_monitor;
  localparam int TO = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        stim_wr_en;
  logic [2:0]  stim_wr_addr;
  logic [31:0] stim_wr_data;
  logic [3:0]  stim_len;
  logic        run;
  logic        in_ack;
  logic [31:0] outPortData;
  logic        stop;
  logic        inPort_en;
  logic [31:0] inPortDataIn;
  logic        log_rd_en;
  logic [31:0] log_rd_data;
  logic        log_empty;
  logic [4:0]  log_count;
  logic        log_overflow;
  logic        done;
  logic        timed_out;
  logic [31:0] cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  io_stim_monitor #(.DATA_W(32), .STIM_DEPTH(8), .LOG_DEPTH(16), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start),
    .stim_wr_en(stim_wr_en), .stim_wr_addr(stim_wr_addr), .stim_wr_data(stim_wr_data),
    .stim_len(stim_len), .run(run), .in_ack(in_ack), .outPortData(outPortData),
    .stop(stop), .inPort_en(inPort_en), .inPortDataIn(inPortDataIn),
    .log_rd_en(log_rd_en), .log_rd_data(log_rd_data), .log_empty(log_empty),
    .log_count(log_count), .log_overflow(log_overflow),
    .done(done), .timed_out(timed_out), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_stim(input logic [2:0] addr, input logic [31:0] data);
    stim_wr_en = 1'b1; stim_wr_addr = addr; stim_wr_data = data;
    step();
    stim_wr_en = 1'b0;
  endtask

  task automatic ack();
    in_ack = 1'b1;
    step();
    in_ack = 1'b0;
  endtask

  task automatic pop();
    log_rd_en = 1'b1;
    step();
    log_rd_en = 1'b0;
  endtask

  task automatic begin_run();
    start = 1'b1; run = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stim_wr_en = 1'b0; stim_wr_addr = '0; stim_wr_data = '0;
    stim_len = 4'd0; run = 1'b0; in_ack = 1'b0; outPortData = '0; log_rd_en = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_stop", 32'(stop), 32'd1);
    check("rst_en", 32'(inPort_en), 32'd0);
    check("rst_data", inPortDataIn, 32'd0);
    check("rst_empty", 32'(log_empty), 32'd1);
    check("rst_count", 32'(log_count), 32'd0);
    check("rst_flags", {29'd0, log_overflow, done, timed_out}, 32'd0);
    check("rst_cycles", cycle_count, 32'd0);

    // T2 stimulus table
    write_stim(3'd0, 32'h80);
    write_stim(3'd1, 32'h11);
    write_stim(3'd2, 32'h22);
    stim_len = 4'd3;
    begin_run();
    check("t2_stop", 32'(stop), 32'd0);
    check("t2_en0", 32'(inPort_en), 32'd1);
    check("t2_d0", inPortDataIn, 32'h80);
    ack();
    check("t2_d1", inPortDataIn, 32'h11);
    ack();
    check("t2_d2", inPortDataIn, 32'h22);
    ack();
`ifdef STIM_LOOP_EN
    check("t2_wrap_d", inPortDataIn, 32'h80);
    check("t2_wrap_en", 32'(inPort_en), 32'd1);
    ack();
    check("t2_wrap_d1", inPortDataIn, 32'h11);
`else
    check("t2_end_d", inPortDataIn, 32'h22);
    check("t2_end_en", 32'(inPort_en), 32'd0);
    ack();
    check("t2_hold_d", inPortDataIn, 32'h22);
    check("t2_hold_en", 32'(inPort_en), 32'd0);
`endif
    check("t2_run_stop", 32'(stop), 32'd0);
    run = 1'b0;
    step();
    check("t2_halt_stop", 32'(stop), 32'd1);
    check("t2_halt_done", 32'(done), 32'd1);

    // T3 halt after 50 running cycles
    begin_run();
    check("t3_done_clr", 32'(done), 32'd0);
    repeat (50) step();
    check("t3_cyc_run", cycle_count, 32'd50);
    check("t3_stop_run", 32'(stop), 32'd0);
    run = 1'b0;
    step();
    check("t3_stop", 32'(stop), 32'd1);
    check("t3_done", 32'(done), 32'd1);
    check("t3_to", 32'(timed_out), 32'd0);
    check("t3_cyc", cycle_count, 32'd50);
    step();
    check("t3_cyc_hold", cycle_count, 32'd50);

    // T4 timeout, start ignored in RUN, run-fall in the timeout cycle
    begin_run();
    check("t4_done_clr", 32'(done), 32'd0);
    check("t4_cyc0", cycle_count, 32'd0);
    repeat (5) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4_start_ign", cycle_count, 32'd6);
    repeat (TO - 7) step();
    check("t4_cyc_last", cycle_count, 32'(TO - 1));
    check("t4_pre_to", 32'(timed_out), 32'd0);
    check("t4_pre_stop", 32'(stop), 32'd0);
    step();
    check("t4_to", 32'(timed_out), 32'd1);
    check("t4_to_stop", 32'(stop), 32'd1);
    check("t4_to_done", 32'(done), 32'd0);
    check("t4_to_cyc", cycle_count, 32'(TO));
    begin_run();
    check("t4_to_clr", 32'(timed_out), 32'd0);
    repeat (TO - 1) step();
    run = 1'b0;
    step();
    check("t4_tie_done", 32'(done), 32'd1);
    check("t4_tie_to", 32'(timed_out), 32'd0);
    check("t4_tie_stop", 32'(stop), 32'd1);
    check("t4_tie_cyc", cycle_count, 32'(TO - 1));

    // T1 reset mid-run
    begin_run();
    repeat (3) step();
    check("t1_running", 32'(stop), 32'd0);
    reset = 1'b1;
    #2;
    check("t1_async_stop", 32'(stop), 32'd1);
    check("t1_en", 32'(inPort_en), 32'd0);
    check("t1_cyc", cycle_count, 32'd0);
    check("t1_flags", {30'd0, done, timed_out}, 32'd0);
    step();
    reset = 1'b0;
    step();
    check("t1_idle_stop", 32'(stop), 32'd1);
    check("t1_idle_en", 32'(inPort_en), 32'd0);
    run = 1'b0;

    // T5 log basics
    outPortData = 32'd0; step();
    check("t5_zero", 32'(log_count), 32'd0);
    outPortData = 32'd5; step();
    outPortData = 32'd5; step();
    outPortData = 32'd9; step();
    check("t5_count", 32'(log_count), 32'd2);
    check("t5_nempty", 32'(log_empty), 32'd0);
    check("t5_head0", log_rd_data, 32'd5);
    pop();
    check("t5_head1", log_rd_data, 32'd9);
    check("t5_count1", 32'(log_count), 32'd1);
    pop();
    check("t5_empty", 32'(log_empty), 32'd1);
    pop();
    check("t5_pop_empty", 32'(log_count), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      outPortData = 32'(100 + i);
      step();
    end
    check("t5_full", 32'(log_count), 32'd16);
    check("t5_no_ovf", 32'(log_overflow), 32'd0);
    outPortData = 32'd117; step();
    check("t5_ovf_count", 32'(log_count), 32'd16);
    check("t5_ovf", 32'(log_overflow), 32'd1);
    check("t5_ovf_head", log_rd_data, 32'd101);

    // T6 push and pop together at full
    outPortData = 32'd200;
    pop();
    check("t6_count", 32'(log_count), 32'd16);
    check("t6_ovf", 32'(log_overflow), 32'd1);
    for (int i = 0; i < 15; i++) begin
      check("t6_order", log_rd_data, 32'(102 + i));
      pop();
    end
    check("t6_tail", log_rd_data, 32'd200);
    pop();
    check("t6_empty", 32'(log_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
